// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: drain FSM states and
// default sizing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_RDY
  } drain_state_t;

  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop, occupancy count and a
// drop flag for pushes refused because the FIFO is full.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // Head is read combinationally; the consumer registers it on pop.
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers bytes from uart_rx and paces them into uart_tx: one push per
// rx_valid rising edge, sticky overflow, and a drain FSM driving tx_en.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     tx_rdy,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);

  drain_state_t state_reg;
  drain_state_t state_next;
  logic         rx_valid_q;
  logic         push;
  logic         pop;
  logic         dropped;
  logic [7:0]   fifo_rd_data;
  logic [7:0]   tx_data_reg;
  logic         overflow_reg;
  logic [BW-1:0] busy_cnt_reg;
  logic         busy_timeout;

  // rx_valid_q resets high so a level already asserted at release is ignored.
  always_ff @(posedge clk) begin
    if (rst) rx_valid_q <= 1'b1;
    else     rx_valid_q <= rx_valid;
  end

  assign push = rx_valid & ~rx_valid_q;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rx_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .dropped (dropped)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)               overflow_reg <= 1'b0;
    else if (dropped)      overflow_reg <= 1'b1;
    else if (clr_overflow) overflow_reg <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)     tx_data_reg <= 8'h00;
    else if (pop) tx_data_reg <= fifo_rd_data;
  end

  // Busy timeout counts from the strobe cycle, so the strobe itself is cycle 1.
  always_ff @(posedge clk) begin
    if (rst)                           busy_cnt_reg <= '0;
    else if (state_reg == S_STROBE)    busy_cnt_reg <= BW'(1);
    else if (state_reg == S_WAIT_BUSY) busy_cnt_reg <= busy_cnt_reg + 1'b1;
  end

  assign busy_timeout = (busy_cnt_reg >= BW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (!empty && tx_rdy) state_next = S_LOAD;
      S_LOAD:      state_next = S_STROBE;
      S_STROBE:    state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_rdy || busy_timeout) state_next = S_WAIT_RDY;
      S_WAIT_RDY:  if (tx_rdy) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    tx_en = 1'b0;
    case (state_reg)
      S_LOAD:   pop   = 1'b1;
      S_STROBE: tx_en = ~rst;
      default:  ;
    endcase
  end

  assign tx_data  = tx_data_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected bytes,
// a negedge monitor checks every tx_en strobe against the queue.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_overflow = 1'b0;
  logic       tx_rdy_force = 1'b0;
  logic       model_en = 1'b0;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [$clog2(DEPTH):0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  int   cyc = 0;
  int   busy_left = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   last_strobe = -1;
  bit   spacing_on = 1'b0;
  exp_t exp_q[$];

  uart_rx_buffer #(.DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_rdy       (tx_rdy),
    .tx_en        (tx_en),
    .tx_data      (tx_data),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for 20 cycles after each strobe.
  always @(posedge clk) begin
    if (model_en && tx_en) busy_left <= 20;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end

  assign tx_rdy = model_en ? (busy_left == 0) : tx_rdy_force;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_en) begin
      exp_t e;
      strobes++;
      if (spacing_on && last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, 7);
      last_strobe = spacing_on ? cyc : -1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got tx_data 0x%02h expected no strobe (cyc %0d)", tx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("strobe cyc %0d tx_data 0x%02h expected 0x%02h", cyc, tx_data, e.data);
        chk("tx_data", tx_data, e.data);
        if (e.cyc >= 0) chk("strobe_latency", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c);
    exp_t t;
    t.data = d;
    t.cyc  = c;
    exp_q.push_back(t);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit queued);
    if (queued) expect_byte(d, -1);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);

    // Single byte, level held 10 cycles: one strobe, 3 cycles after the edge
    tx_rdy_force = 1'b1;
    tick();
    s0 = strobes;
    expect_byte(8'hA5, cyc + 3);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (10) tick();
    rx_valid = 1'b0;
    wait_drain(100);
    repeat (15) tick();
    chk("single_strobe_count", strobes - s0, 1);
    chk("single_count_after", count, 0);

    // Five bytes buffered while uart_tx is not ready, then drained in order
    tx_rdy_force = 1'b0;
    s0 = strobes;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
    chk("five_count", count, 5);
    chk("five_no_strobe", strobes - s0, 0);
    model_en = 1'b1;
    wait_drain(500);
    repeat (30) tick();
    model_en = 1'b0;
    chk("five_strobes", strobes - s0, 5);
    chk("five_empty", empty, 1);

    // Overfill: the 17th byte is dropped and overflow latches
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i), i < 16);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_overflow", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_overflow", overflow, 0);
    rx_valid     = 1'b1;
    rx_data      = 8'h21;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    rx_valid     = 1'b0;
    tick();
    chk("ovf_beats_clr", overflow, 1);
    chk("ovf_count", count, 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_overflow_2", overflow, 0);

    // Full FIFO: push edge lands on the S_LOAD pop; tx_rdy never drops
    spacing_on   = 1'b1;
    tx_rdy_force = 1'b1;
    tick();
    expect_byte(8'h77, -1);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    rx_valid = 1'b0;
    chk("pushpop_full_count", count, 16);
    chk("pushpop_full_overflow", overflow, 0);
    wait_drain(300);
    spacing_on = 1'b0;
    repeat (10) tick();
    chk("pushpop_drained", count, 0);

    // Reset in S_WAIT_BUSY with three bytes queued; rx_valid high across reset
    tx_rdy_force = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i), 1'b1);
    chk("pre_rst_count4", count, 4);
    tx_rdy_force = 1'b1;
    n = 0;
    while (tx_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("pre_rst_strobe_seen", tx_en, 1);
    tick();
    chk("wait_busy_count3", count, 3);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    exp_q.delete();
    tick();
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_tx_en", tx_en, 0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("no_push_after_rst", count, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_tx_data", tx_data, 8'h00);
    rx_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
